// File: rtl/ra_stack_param_if.sv
// ---------------------------------------------------------------------------
// ra_stack_param_if
// Bundles the request and status signals of the return-address stack so the
// core (or a bench) connects through one port.
//   master modport : drives stack_ena, clear, push, pop, push_din, pop_din;
//                    observes every status output.
//   slave modport  : the stack itself; the reverse directions.
// Parameters: WIDTH = address width, CW = occupancy count width.
// ---------------------------------------------------------------------------
interface ra_stack_param_if #(
   parameter int WIDTH = 32,
   parameter int CW    = 5
);

   logic             stack_ena;
   logic             clear;
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] push_din;
   logic [WIDTH-1:0] pop_din;
   logic [WIDTH-1:0] stack_top;
   logic [CW-1:0]    stack_count;
   logic             stack_full;
   logic             stack_empty;
   logic             stack_mismatch;
   logic [WIDTH-1:0] mismatch_addr;
   logic             overflow;
   logic             underflow;

   modport master (
      output stack_ena, clear, push, pop, push_din, pop_din,
      input  stack_top, stack_count, stack_full, stack_empty,
             stack_mismatch, mismatch_addr, overflow, underflow
   );

   modport slave (
      input  stack_ena, clear, push, pop, push_din, pop_din,
      output stack_top, stack_count, stack_full, stack_empty,
             stack_mismatch, mismatch_addr, overflow, underflow
   );

endinterface

// File: rtl/ra_stack_param.sv
// ---------------------------------------------------------------------------
// ra_stack_param
// Return-address stack used as a control-flow integrity checker. Calls push
// the link address, returns pop and compare the real target against the
// stored one. Supports simultaneous push+pop (coroutine swap), flush, a
// drop-or-overwrite overflow policy and sticky or pulsed mismatch reporting.
//
// Ports:
//   clk  : clock
//   Rst  : synchronous active-high reset
//   bus  : ra_stack_param_if.slave
//          in : stack_ena, clear, push, pop, push_din, pop_din
//          out: stack_top (0 when empty), stack_count, stack_full,
//               stack_empty, stack_mismatch, mismatch_addr,
//               overflow (pulse), underflow (pulse)
// Parameters: WIDTH, DEPTH (>=2, any value), OVF_WRAP (0 drop / 1 overwrite
//   oldest), STICKY (1 hold mismatch / 0 pulse), CW (derived count width).
// ---------------------------------------------------------------------------
module ra_stack_param #(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 16,
   parameter int OVF_WRAP = 0,
   parameter int STICKY   = 1,
   parameter int CW       = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               Rst,
   ra_stack_param_if.slave    bus
);

   localparam int            PW    = $clog2(DEPTH);
   localparam logic [PW-1:0] LAST  = PW'(DEPTH - 1);
   localparam logic [CW-1:0] FULLC = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    tp;
   logic [CW-1:0]    count;
   logic             mismatch_q;
   logic [WIDTH-1:0] maddr_q;
   logic             ovf_q;
   logic             unf_q;

   logic             empty;
   logic             full;
   logic [PW-1:0]    tp_inc;
   logic [PW-1:0]    tp_dec;
   logic             do_push;
   logic             do_pop;
   logic [WIDTH-1:0] top_val;
   logic             mm_event;

   // Occupancy flags and modulo-DEPTH pointer neighbours. DEPTH need not be a
   // power of two, so the wrap is an explicit compare rather than overflow.
   always_comb begin
      empty    = (count == '0);
      full     = (count == FULLC);
      tp_inc   = (tp == LAST) ? '0 : tp + 1'b1;
      tp_dec   = (tp == '0) ? LAST : tp - 1'b1;
      do_push  = bus.stack_ena & bus.push;
      do_pop   = bus.stack_ena & bus.pop;
      top_val  = mem[tp];
      mm_event = do_pop & ~empty & (bus.pop_din != top_val);
   end

   // Entry storage. A swap (push+pop on a non-empty stack) replaces the top in
   // place; otherwise a push lands one above the top, which when full and
   // wrapping is the oldest slot. Contents are never reset - count guards them.
   always_ff @(posedge clk) begin
      if (!Rst && !bus.clear && do_push) begin
         if (do_pop && !empty) begin
            mem[tp] <= bus.push_din;
         end else if (!full || (OVF_WRAP != 0)) begin
            mem[tp_inc] <= bus.push_din;
         end
      end
   end

   // Pointer, count and reporting flags. Reset wins over clear, clear wins over
   // any request. overflow/underflow are single-cycle pulses recomputed every
   // edge. In sticky mode only the first mismatch is captured.
   always_ff @(posedge clk) begin
      if (Rst) begin
         tp         <= '0;
         count      <= '0;
         mismatch_q <= 1'b0;
         maddr_q    <= '0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
      end else if (bus.clear) begin
         count      <= '0;
         mismatch_q <= 1'b0;
         maddr_q    <= '0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
      end else begin
         ovf_q <= do_push & ~do_pop & full;
         unf_q <= do_pop & empty;

         if (STICKY != 0) begin
            if (mm_event && !mismatch_q) begin
               mismatch_q <= 1'b1;
               maddr_q    <= bus.pop_din;
            end
         end else begin
            mismatch_q <= mm_event;
            if (mm_event) begin
               maddr_q <= bus.pop_din;
            end
         end

         if (do_push && do_pop) begin
            if (empty) begin
               tp    <= tp_inc;
               count <= CW'(1);
            end
         end else if (do_push) begin
            if (!full) begin
               tp    <= tp_inc;
               count <= count + 1'b1;
            end else if (OVF_WRAP != 0) begin
               tp <= tp_inc;
            end
         end else if (do_pop && !empty) begin
            tp    <= tp_dec;
            count <= count - 1'b1;
         end
      end
   end

   assign bus.stack_top      = empty ? '0 : top_val;
   assign bus.stack_count    = count;
   assign bus.stack_full     = full;
   assign bus.stack_empty    = empty;
   assign bus.stack_mismatch = mismatch_q;
   assign bus.mismatch_addr  = maddr_q;
   assign bus.overflow       = ovf_q;
   assign bus.underflow      = unf_q;

endmodule

// File: tb/tb_ra_stack_param.sv
// ---------------------------------------------------------------------------
// tb_ra_stack_param
// Three stack instances: d0 DEPTH=4 drop-on-full sticky, d1 DEPTH=4
// overwrite-oldest sticky, d2 DEPTH=5 overwrite-oldest pulsed mismatch.
// Each request pushes its hand-computed expected next state into a queue; a
// monitor pops and compares just after every rising edge.
// ---------------------------------------------------------------------------
module tb_ra_stack_param;

   logic clk = 1'b0;
   logic Rst = 1'b1;

   always #5 clk = ~clk;

   ra_stack_param_if #(.WIDTH(32), .CW(3)) bus0 ();
   ra_stack_param_if #(.WIDTH(32), .CW(3)) bus1 ();
   ra_stack_param_if #(.WIDTH(32), .CW(3)) bus2 ();

   ra_stack_param #(.WIDTH(32), .DEPTH(4), .OVF_WRAP(0), .STICKY(1)) dut0 (
      .clk(clk), .Rst(Rst), .bus(bus0));
   ra_stack_param #(.WIDTH(32), .DEPTH(4), .OVF_WRAP(1), .STICKY(1)) dut1 (
      .clk(clk), .Rst(Rst), .bus(bus1));
   ra_stack_param #(.WIDTH(32), .DEPTH(5), .OVF_WRAP(1), .STICKY(0)) dut2 (
      .clk(clk), .Rst(Rst), .bus(bus2));

   typedef struct {
      int          d;
      string       nm;
      int          cnt;
      logic [31:0] top;
      logic        mm;
      logic [31:0] maddr;
      logic        ovf;
      logic        unf;
   } exp_t;

   exp_t sbq[$];
   int   nCmp  = 0;
   int   nMiss = 0;

   // One comparison: counts it, reports a miss with actual and required values.
   task automatic checkOutput(input string nm, input string field,
                              input logic [31:0] act, input logic [31:0] exp);
      nCmp++;
      if (act !== exp) begin
         nMiss++;
         $display("[TB] FAIL %s.%s actual=%0h required=%0h", nm, field, act, exp);
      end
   endtask

   // Put the idle pattern on every bus, then the requested op on instance d.
   task automatic driveDut(input int d, input bit ena, input bit clr, input bit psh,
                           input bit pp, input logic [31:0] pdin, input logic [31:0] podin);
      bus0.stack_ena = 0; bus0.clear = 0; bus0.push = 0; bus0.pop = 0;
      bus0.push_din = '0; bus0.pop_din = '0;
      bus1.stack_ena = 0; bus1.clear = 0; bus1.push = 0; bus1.pop = 0;
      bus1.push_din = '0; bus1.pop_din = '0;
      bus2.stack_ena = 0; bus2.clear = 0; bus2.push = 0; bus2.pop = 0;
      bus2.push_din = '0; bus2.pop_din = '0;
      case (d)
         0: begin
            bus0.stack_ena = ena; bus0.clear = clr; bus0.push = psh; bus0.pop = pp;
            bus0.push_din = pdin; bus0.pop_din = podin;
         end
         1: begin
            bus1.stack_ena = ena; bus1.clear = clr; bus1.push = psh; bus1.pop = pp;
            bus1.push_din = pdin; bus1.pop_din = podin;
         end
         2: begin
            bus2.stack_ena = ena; bus2.clear = clr; bus2.push = psh; bus2.pop = pp;
            bus2.push_din = pdin; bus2.pop_din = podin;
         end
         default: ;
      endcase
   endtask

   // Called on a falling edge: drive one request, queue the state expected
   // after the next rising edge, and move on to the following falling edge.
   task automatic applyStimulus(input int d, input string nm, input bit ena, input bit clr,
                                input bit psh, input bit pp, input logic [31:0] pdin,
                                input logic [31:0] podin, input int cnt, input logic [31:0] top,
                                input bit mm, input logic [31:0] maddr, input bit ovf, input bit unf);
      exp_t e;
      driveDut(d, ena, clr, psh, pp, pdin, podin);
      e.d = d; e.nm = nm; e.cnt = cnt; e.top = top; e.mm = mm;
      e.maddr = maddr; e.ovf = ovf; e.unf = unf;
      sbq.push_back(e);
      @(negedge clk);
   endtask

   // Synchronous reset of all instances for one edge; every instance must
   // come out empty with all flags low.
   task automatic applyReset();
      exp_t e;
      driveDut(-1, 0, 0, 0, 0, '0, '0);
      Rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         e.d = k; e.nm = "reset"; e.cnt = 0; e.top = '0; e.mm = 1'b0;
         e.maddr = '0; e.ovf = 1'b0; e.unf = 1'b0;
         sbq.push_back(e);
      end
      @(negedge clk);
      Rst = 1'b0;
   endtask

   // Monitor: just after each rising edge, compare every queued expectation
   // against the instance it names.
   initial begin : monitor
      exp_t        e;
      int          depth;
      logic [31:0] a_top, a_maddr;
      logic [2:0]  a_cnt;
      logic        a_full, a_empty, a_mm, a_ovf, a_unf;
      forever begin
         @(posedge clk);
         #1;
         while (sbq.size() > 0) begin
            e = sbq.pop_front();
            case (e.d)
               0: begin
                  depth = 4; a_top = bus0.stack_top; a_cnt = bus0.stack_count;
                  a_full = bus0.stack_full; a_empty = bus0.stack_empty;
                  a_mm = bus0.stack_mismatch; a_maddr = bus0.mismatch_addr;
                  a_ovf = bus0.overflow; a_unf = bus0.underflow;
               end
               1: begin
                  depth = 4; a_top = bus1.stack_top; a_cnt = bus1.stack_count;
                  a_full = bus1.stack_full; a_empty = bus1.stack_empty;
                  a_mm = bus1.stack_mismatch; a_maddr = bus1.mismatch_addr;
                  a_ovf = bus1.overflow; a_unf = bus1.underflow;
               end
               default: begin
                  depth = 5; a_top = bus2.stack_top; a_cnt = bus2.stack_count;
                  a_full = bus2.stack_full; a_empty = bus2.stack_empty;
                  a_mm = bus2.stack_mismatch; a_maddr = bus2.mismatch_addr;
                  a_ovf = bus2.overflow; a_unf = bus2.underflow;
               end
            endcase
            checkOutput($sformatf("d%0d.%s", e.d, e.nm), "count", 32'(a_cnt), 32'(e.cnt));
            checkOutput($sformatf("d%0d.%s", e.d, e.nm), "top", a_top, e.top);
            checkOutput($sformatf("d%0d.%s", e.d, e.nm), "full", 32'(a_full), 32'(e.cnt == depth));
            checkOutput($sformatf("d%0d.%s", e.d, e.nm), "empty", 32'(a_empty), 32'(e.cnt == 0));
            checkOutput($sformatf("d%0d.%s", e.d, e.nm), "mismatch", 32'(a_mm), 32'(e.mm));
            checkOutput($sformatf("d%0d.%s", e.d, e.nm), "maddr", a_maddr, e.maddr);
            checkOutput($sformatf("d%0d.%s", e.d, e.nm), "overflow", 32'(a_ovf), 32'(e.ovf));
            checkOutput($sformatf("d%0d.%s", e.d, e.nm), "underflow", 32'(a_unf), 32'(e.unf));
         end
      end
   end

   // Hard bound on simulation time in case the stimulus ever stalls.
   initial begin : watchdog
      #100000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] time limit expired");
   end

   // Directed stimulus with hand-computed expected state.
   initial begin : stimulus
      driveDut(-1, 0, 0, 0, 0, '0, '0);
      @(negedge clk);
      applyReset();

      // d0: basic push/pop, sticky mismatch, clear
      applyStimulus(0, "push100", 1,0,1,0, 'h100, 0,   1, 'h100, 0, 0, 0, 0);
      applyStimulus(0, "push200", 1,0,1,0, 'h200, 0,   2, 'h200, 0, 0, 0, 0);
      applyStimulus(0, "push300", 1,0,1,0, 'h300, 0,   3, 'h300, 0, 0, 0, 0);
      applyStimulus(0, "pop300",  1,0,0,1, 0, 'h300,   2, 'h200, 0, 0, 0, 0);
      applyStimulus(0, "pop1234", 1,0,0,1, 0, 'h1234,  1, 'h100, 1, 'h1234, 0, 0);
      applyStimulus(0, "pop5555", 1,0,0,1, 0, 'h5555,  0, 0,     1, 'h1234, 0, 0);
      applyStimulus(0, "clear",   1,1,0,0, 0, 0,       0, 0,     0, 0, 0, 0);

      // d0: fill to DEPTH=4, dropped fifth push, drain
      for (int i = 1; i <= 4; i++)
         applyStimulus(0, $sformatf("fill%0d", i), 1,0,1,0, 32'(i), 0, i, 32'(i), 0, 0, 0, 0);
      applyStimulus(0, "push5drop", 1,0,1,0, 5, 0, 4, 4, 0, 0, 1, 0);
      for (int i = 4; i >= 1; i--)
         applyStimulus(0, $sformatf("drain%0d", i), 1,0,0,1, 0, 32'(i), i-1, 32'(i-1), 0, 0, 0, 0);

      // d0: coroutine swap on non-empty and empty stacks
      applyStimulus(0, "pushA0",    1,0,1,0, 'hA0, 0,     1, 'hA0, 0, 0, 0, 0);
      applyStimulus(0, "swap",      1,0,1,1, 'hB0, 'hA0,  1, 'hB0, 0, 0, 0, 0);
      applyStimulus(0, "popB0",     1,0,0,1, 0, 'hB0,     0, 0,    0, 0, 0, 0);
      applyStimulus(0, "swapEmpty", 1,0,1,1, 'hB0, 'hA0,  1, 'hB0, 0, 0, 0, 1);
      applyStimulus(0, "popB0b",    1,0,0,1, 0, 'hB0,     0, 0,    0, 0, 0, 0);

      // d0: build count=3 with mismatch set, then reset mid-sequence
      applyStimulus(0, "push11",  1,0,1,0, 'h11, 0,  1, 'h11, 0, 0,    0, 0);
      applyStimulus(0, "push22",  1,0,1,0, 'h22, 0,  2, 'h22, 0, 0,    0, 0);
      applyStimulus(0, "pop99",   1,0,0,1, 0, 'h99,  1, 'h11, 1, 'h99, 0, 0);
      applyStimulus(0, "push22b", 1,0,1,0, 'h22, 0,  2, 'h22, 1, 'h99, 0, 0);
      applyStimulus(0, "push33",  1,0,1,0, 'h33, 0,  3, 'h33, 1, 'h99, 0, 0);
      applyReset();

      // d0: disabled push ignored, underflow pulse and its release
      applyStimulus(0, "enaOff",   0,0,1,0, 'h77, 0,  0, 0, 0, 0, 0, 0);
      applyStimulus(0, "popEmpty", 1,0,0,1, 0, 'h5,   0, 0, 0, 0, 0, 1);
      applyStimulus(0, "idle",     1,0,0,0, 0, 0,     0, 0, 0, 0, 0, 0);

      // d1: overwrite-oldest overflow, drain, underflow
      for (int i = 1; i <= 6; i++)
         applyStimulus(1, $sformatf("push%0d", i), 1,0,1,0, 32'(i), 0,
                       (i > 4) ? 4 : i, 32'(i), 0, 0, (i > 4), 0);
      for (int i = 6; i >= 3; i--)
         applyStimulus(1, $sformatf("pop%0d", i), 1,0,0,1, 0, 32'(i),
                       i-3, (i == 3) ? 32'd0 : 32'(i-1), 0, 0, 0, 0);
      applyStimulus(1, "popUnder", 1,0,0,1, 0, 'h3, 0, 0, 0, 0, 0, 1);

      // d2: DEPTH=5 wrap, pulsed mismatch with per-event address capture
      for (int i = 1; i <= 7; i++)
         applyStimulus(2, $sformatf("push%0d", i), 1,0,1,0, 32'(i), 0,
                       (i > 5) ? 5 : i, 32'(i), 0, 0, (i > 5), 0);
      applyStimulus(2, "pop9", 1,0,0,1, 0, 'h9, 4, 6, 1, 'h9, 0, 0);
      applyStimulus(2, "pop8", 1,0,0,1, 0, 'h8, 3, 5, 1, 'h8, 0, 0);
      applyStimulus(2, "pop5", 1,0,0,1, 0, 'h5, 2, 4, 0, 'h8, 0, 0);
      applyStimulus(2, "pop4", 1,0,0,1, 0, 'h4, 1, 3, 0, 'h8, 0, 0);
      applyStimulus(2, "pop3", 1,0,0,1, 0, 'h3, 0, 0, 0, 'h8, 0, 0);
      applyStimulus(2, "idle", 1,0,0,0, 0, 0,   0, 0, 0, 'h8, 0, 0);

      driveDut(-1, 0, 0, 0, 0, '0, '0);
      @(posedge clk);
      #2;
      nCmp++;
      if (sbq.size() != 0) begin
         nMiss++;
         $display("[TB] FAIL scoreboard_drain actual=%0d required=0", sbq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nCmp, nMiss);
      $finish;
   end

endmodule
